systolic_psum_manager: RTL and testbench

Parametrised successor to the systolic output path. It accepts one N_SIZE-lane result row per cycle from the systolic array and performs read-modify-write accumulation of partial sums across K tiles internally, so the fetch logic no longer feeds partial sums back. Final rows go to a ping-pong output bank pair, which a downstream consumer drains over a valid/ready stream while the next tile accumulates. Optional saturating arithmetic and per-tile row count.

---
 rtl/systolic_psum_manager.sv | 226 ++++++++++++++++++++++
 tb/tb_systolic_psum_manager.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_psum_manager.sv
// Partial-sum manager for the systolic array output path.
// Accumulates K tiles of N_SIZE-lane rows in a local psum RAM. The last
// tile of a sequence lands in one of two output banks, which are drained
// over a valid/ready stream while the next tile accumulates.
module systolic_psum_manager #(
  parameter int N_SIZE     = 32,
  parameter int IN_WIDTH   = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int ROWS       = 512,
  parameter int ADDR_WIDTH = 10,
  parameter int SATURATE   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tile_start,
  input  logic                          first_tile,
  input  logic                          last_tile,
  input  logic [ADDR_WIDTH:0]           tile_rows,
  output logic                          tile_ready,
  input  logic                          in_valid,
  input  logic [N_SIZE*IN_WIDTH-1:0]    in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_SIZE*ACC_WIDTH-1:0]   out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          err
);

  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RW = N_SIZE * ACC_WIDTH;
  localparam logic [ADDR_WIDTH:0] ROWS_L = (ADDR_WIDTH+1)'(ROWS);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t                  state, state_nxt;
  logic                    first_q, last_q;
  logic [ADDR_WIDTH:0]     rows_q, row_cnt;
  logic [1:0]              bank_full;
  logic                    wr_bank, rd_bank;
  logic [ADDR_WIDTH:0]     bank_rows [2];
  logic [ADDR_WIDTH:0]     rd_ptr;

  logic [RW-1:0]           psum_mem  [ROWS];
  logic [RW-1:0]           obank_mem [2][ROWS];

  logic                    vld_p1;
  logic [AW-1:0]           addr_p1;
  logic [N_SIZE*IN_WIDTH-1:0] in_p1;
  logic [RW-1:0]           psum_p1;
  logic [RW-1:0]           sum_p1;

  logic                    rd_vld_p1, rd_last_p1;
  logic [RW-1:0]           rd_data_p1;
  logic                    skid_vld, skid_last;
  logic [RW-1:0]           skid_data;

  logic accept, rows_ok, start_ok, start_bad, flush_set, pop, drain_done, issue;
  logic [1:0] occ;

  // Full-precision add: sign-extend both operands to ACC_WIDTH+1 bits.
  function automatic logic signed [ACC_WIDTH:0] add_full(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [IN_WIDTH-1:0]  b
  );
    logic signed [ACC_WIDTH:0] ax, bx;
    ax = {a[ACC_WIDTH-1], a};
    bx = {{(ACC_WIDTH+1-IN_WIDTH){b[IN_WIDTH-1]}}, b};
    return ax + bx;
  endfunction

  // Clamp to the signed ACC_WIDTH range, or wrap by dropping the top bit.
  function automatic logic signed [ACC_WIDTH-1:0] sat_wrap(
    input logic signed [ACC_WIDTH:0] s
  );
    if ((SATURATE != 0) && (s[ACC_WIDTH] != s[ACC_WIDTH-1]))
      return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return s[ACC_WIDTH-1:0];
  endfunction

  assign accept     = in_valid && (state == ACCUM);
  assign rows_ok    = (tile_rows != '0) && (tile_rows <= ROWS_L);
  assign start_ok   = tile_start && tile_ready && rows_ok;
  assign start_bad  = tile_start && tile_ready && !rows_ok;
  assign flush_set  = (state == FLUSH) && last_q;
  assign pop        = out_valid && out_ready;
  assign drain_done = pop && out_last;
  // Rows held or in flight after this cycle's pop must fit the 2-entry skid.
  assign occ        = 2'(out_valid) + 2'(skid_vld) + 2'(rd_vld_p1);
  assign issue      = bank_full[rd_bank] && (rd_ptr != bank_rows[rd_bank]) &&
                      (occ < (2'd2 + 2'(pop)));

  // Tile FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Tile FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = ACCUM;
      ACCUM:   if (accept && (row_cnt == rows_q - 1'b1)) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tile FSM outputs.
  always_comb begin
    tile_ready = (state == IDLE) && !bank_full[wr_bank];
    busy       = (state != IDLE);
  end

  // Tile bookkeeping: latched qualifiers, row counter, sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q <= 1'b0;
      last_q  <= 1'b0;
      rows_q  <= '0;
      row_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (start_ok) begin
        first_q <= first_tile;
        last_q  <= last_tile;
        rows_q  <= tile_rows;
        row_cnt <= '0;
      end else if (accept) begin
        row_cnt <= row_cnt + 1'b1;
      end
      if (start_bad || (in_valid && (state != ACCUM))) err <= 1'b1;
    end
  end

  // Stage p0 -> p1: capture the incoming row and read its partial sum.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= accept;
    if (accept) begin
      addr_p1 <= row_cnt[AW-1:0];
      in_p1   <= in_data;
      psum_p1 <= psum_mem[row_cnt[AW-1:0]];
    end
  end

  // Stage p1 add: first tile ignores the stale partial sum.
  always_comb begin
    sum_p1 = '0;
    for (int i = 0; i < N_SIZE; i++)
      sum_p1[i*ACC_WIDTH +: ACC_WIDTH] = sat_wrap(add_full(
        first_q ? '0 : psum_p1[i*ACC_WIDTH +: ACC_WIDTH],
        in_p1[i*IN_WIDTH +: IN_WIDTH]));
  end

  // Stage p1 write-back: psum for intermediate tiles, output bank for the last.
  always_ff @(posedge clk) begin
    if (vld_p1 && rst_n) begin
      if (last_q) obank_mem[wr_bank][addr_p1] <= sum_p1;
      else        psum_mem[addr_p1]           <= sum_p1;
    end
  end

  // Ping-pong bank ownership; fill and drain of opposite banks may coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      rd_ptr    <= '0;
    end else begin
      bank_full <= (bank_full | (flush_set ? (2'b01 << wr_bank) : 2'b00))
                   & ~(drain_done ? (2'b01 << rd_bank) : 2'b00);
      if (flush_set) begin
        bank_rows[wr_bank] <= rows_q;
        wr_bank            <= ~wr_bank;
      end
      if (drain_done) begin
        rd_bank <= ~rd_bank;
        rd_ptr  <= '0;
      end else if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Drain read stage: one-cycle output bank read.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_vld_p1 <= 1'b0;
    else        rd_vld_p1 <= issue;
    if (issue) begin
      rd_data_p1 <= obank_mem[rd_bank][rd_ptr[AW-1:0]];
      rd_last_p1 <= (rd_ptr + 1'b1 == bank_rows[rd_bank]);
    end
  end

  // Output register plus skid entry; head holds steady while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      skid_vld  <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_vld) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
        out_last  <= skid_last;
        skid_vld  <= rd_vld_p1;
        skid_data <= rd_data_p1;
        skid_last <= rd_last_p1;
      end else begin
        out_valid <= rd_vld_p1;
        out_last  <= rd_vld_p1 && rd_last_p1;
        if (rd_vld_p1) out_data <= rd_data_p1;
      end
    end else if (rd_vld_p1) begin
      skid_vld  <= 1'b1;
      skid_data <= rd_data_p1;
      skid_last <= rd_last_p1;
    end
  end

endmodule

// File: tb/tb_systolic_psum_manager.sv
// Bench for systolic_psum_manager: three instances share stimulus
// (8-bit saturating, 8-bit wrapping, 12-bit saturating accumulators) and
// are checked row-by-row against an arithmetic reference model.
module tb_systolic_psum_manager;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int RR = 8;
  localparam int AWD = 4;

  typedef struct packed {
    logic        last;
    logic [31:0] a;
    logic [31:0] b;
    logic [47:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, tile_start, first_tile, last_tile, in_valid, out_ready;
  logic [AWD:0]    tile_rows;
  logic [N*IW-1:0] in_data;

  logic tile_ready_a, out_valid_a, out_last_a, busy_a, err_a;
  logic tile_ready_b, out_valid_b, out_last_b, busy_b, err_b;
  logic tile_ready_c, out_valid_c, out_last_c, busy_c, err_c;
  logic [31:0] out_data_a, out_data_b;
  logic [47:0] out_data_c;

  int n_chk = 0;
  int n_err = 0;
  int rdy_mode = 1;
  exp_t exp_q[$];
  int pa[RR][N], pb[RR][N], pc[RR][N];

  always #5 clk = ~clk;

  systolic_psum_manager #(.N_SIZE(N), .IN_WIDTH(IW), .ACC_WIDTH(8), .ROWS(RR),
    .ADDR_WIDTH(AWD), .SATURATE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tile_start(tile_start), .first_tile(first_tile),
    .last_tile(last_tile), .tile_rows(tile_rows), .tile_ready(tile_ready_a),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_last(out_last_a),
    .busy(busy_a), .err(err_a));

  systolic_psum_manager #(.N_SIZE(N), .IN_WIDTH(IW), .ACC_WIDTH(8), .ROWS(RR),
    .ADDR_WIDTH(AWD), .SATURATE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .tile_start(tile_start), .first_tile(first_tile),
    .last_tile(last_tile), .tile_rows(tile_rows), .tile_ready(tile_ready_b),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b),
    .busy(busy_b), .err(err_b));

  systolic_psum_manager #(.N_SIZE(N), .IN_WIDTH(IW), .ACC_WIDTH(12), .ROWS(RR),
    .ADDR_WIDTH(AWD), .SATURATE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .tile_start(tile_start), .first_tile(first_tile),
    .last_tile(last_tile), .tile_rows(tile_rows), .tile_ready(tile_ready_c),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_data(out_data_c), .out_last(out_last_c),
    .busy(busy_c), .err(err_c));

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic int sat(input int x, input int w);
    int lo, hi;
    lo = -(1 << (w-1));
    hi = (1 << (w-1)) - 1;
    return (x > hi) ? hi : (x < lo) ? lo : x;
  endfunction

  function automatic int wrap(input int x, input int w);
    int m, y;
    m = 1 << w;
    y = ((x % m) + m) % m;
    return (y >= m/2) ? y - m : y;
  endfunction

  // Consumer ready: held low, held high, or random per cycle.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pop expected row on each handshake, check stall stability.
  logic        prev_stall = 1'b0;
  logic [33:0] snap;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_stable", 64'({out_valid_a, out_last_a, out_data_a}), 64'(snap));
      if (out_valid_a && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", 64'(out_data_a), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("row_sat8",  64'(out_data_a), 64'(e.a));
          chk("row_wrap8", 64'(out_data_b), 64'(e.b));
          chk("row_sat12", 64'(out_data_c), 64'(e.c));
          chk("row_last",  64'({out_last_a, out_last_b, out_last_c}), 64'({3{e.last}}));
          chk("row_vld_bc", 64'({out_valid_b, out_valid_c}), 64'(2'b11));
        end
      end
      prev_stall = out_valid_a && !out_ready;
      snap = {out_valid_a, out_last_a, out_data_a};
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!tile_ready_a && n < 3000) begin @(posedge clk); #1; n++; end
    if (!tile_ready_a) chk("tile_ready_timeout", 64'(tile_ready_a), 64'(1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid_a) && n < 5000) begin @(posedge clk); #1; n++; end
    if (n >= 5000) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  // Issue one tile; mode 0 random lanes, 1 constant cval, 2 lane=i+row.
  task automatic run_tile(input bit f, input bit l, input int rows, input int mode, input int cval);
    exp_t tq[$];
    exp_t e;
    int v, ra, rb, rc;
    logic [N*IW-1:0] din;
    wait_ready();
    tile_start = 1'b1; first_tile = f; last_tile = l; tile_rows = rows[AWD:0];
    @(posedge clk); #1;
    tile_start = 1'b0;
    for (int r = 0; r < rows; r++) begin
      while ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      e = '0;
      for (int i = 0; i < N; i++) begin
        case (mode)
          0:       v = int'($urandom_range(0, 255)) - 128;
          1:       v = cval;
          default: v = i + r;
        endcase
        din[i*IW +: IW] = v[7:0];
        ra = sat((f ? 0 : pa[r][i]) + v, 8);
        rb = wrap((f ? 0 : pb[r][i]) + v, 8);
        rc = sat((f ? 0 : pc[r][i]) + v, 12);
        if (l) begin
          e.a[i*8 +: 8]   = ra[7:0];
          e.b[i*8 +: 8]   = rb[7:0];
          e.c[i*12 +: 12] = rc[11:0];
        end else begin
          pa[r][i] = ra; pb[r][i] = rb; pc[r][i] = rc;
        end
      end
      e.last = (r == rows - 1);
      if (l) tq.push_back(e);
      in_valid = 1'b1; in_data = din;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    foreach (tq[k]) exp_q.push_back(tq[k]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic bad_start(input int rows);
    wait_ready();
    tile_start = 1'b1; first_tile = 1'b1; last_tile = 1'b1; tile_rows = rows[AWD:0];
    @(posedge clk); #1;
    tile_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tile_start = 1'b0; first_tile = 1'b0; last_tile = 1'b0;
    tile_rows = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk); #1;
    chk("reset_ctrl", 64'({out_valid_a, out_last_a, busy_a, err_a, tile_ready_a}), 64'(5'b00001));
    chk("reset_data", 64'({out_data_a, out_data_b}), 64'(0));
    rst_n = 1'b1;

    // Single tile, lane = i + row.
    run_tile(1, 1, 3, 2, 0);
    wait_drain();

    // K=3 accumulation, twice (second run must overwrite, not add).
    for (int s = 0; s < 2; s++) begin
      run_tile(1, 0, 2, 1, 5);
      run_tile(0, 0, 2, 1, 5);
      run_tile(0, 1, 2, 1, 5);
    end
    wait_drain();

    // Overflow in both directions.
    run_tile(1, 0, 1, 1, 100);
    run_tile(0, 1, 1, 1, 100);
    run_tile(1, 0, 1, 1, -100);
    run_tile(0, 1, 1, 1, -100);
    wait_drain();

    // Ping-pong with the consumer stalled.
    rdy_mode = 0;
    @(posedge clk); #1;
    run_tile(1, 1, 3, 0, 0);
    run_tile(1, 1, 3, 0, 0);
    repeat (2) @(posedge clk); #1;
    chk("both_full_not_ready", 64'(tile_ready_a), 64'(0));
    chk("both_full_idle", 64'(busy_a), 64'(0));
    tile_start = 1'b1; first_tile = 1'b1; last_tile = 1'b1; tile_rows = 5'd2;
    @(posedge clk); #1;
    tile_start = 1'b0;
    chk("start_ignored", 64'(busy_a), 64'(0));
    repeat (20) @(posedge clk); #1;
    rdy_mode = 2;
    run_tile(1, 1, 4, 0, 0);
    wait_drain();

    // Random tiles while draining with a random consumer.
    run_tile(1, 0, RR, 0, 0);
    for (int t = 0; t < 40; t++)
      run_tile(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
               int'($urandom_range(1, RR)), 0, 0);
    wait_drain();

    // Reset in the middle of an accumulating tile.
    rdy_mode = 1;
    wait_ready();
    tile_start = 1'b1; first_tile = 1'b1; last_tile = 1'b1; tile_rows = 5'd4;
    @(posedge clk); #1;
    tile_start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      in_valid = 1'b1; in_data = N*IW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid_accum_busy", 64'(busy_a), 64'(1));
    do_reset();
    chk("mid_reset_ctrl", 64'({out_valid_a, out_last_a, busy_a, err_a, tile_ready_a}), 64'(5'b00001));
    chk("mid_reset_data", 64'(out_data_a), 64'(0));
    run_tile(1, 0, RR, 0, 0);
    run_tile(0, 1, RR, 0, 0);
    wait_drain();
    chk("no_spurious_err", 64'({err_a, err_b, err_c}), 64'(0));

    // Error cases.
    bad_start(0);
    chk("zero_rows_err", 64'(err_a), 64'(1));
    chk("zero_rows_idle", 64'(busy_a), 64'(0));
    do_reset();
    chk("err_cleared", 64'(err_a), 64'(0));
    bad_start(RR + 1);
    chk("too_many_rows_err", 64'(err_a), 64'(1));
    chk("too_many_rows_idle", 64'(busy_a), 64'(0));
    do_reset();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("idle_valid_err", 64'(err_a), 64'(1));
    do_reset();
    repeat (3) @(posedge clk); #1;
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
